mem_state_dump: RTL and testbench

Hardware state-dump engine for the RISC-V core. On request it halts the core and reads architectural state through read-only ports, in order: register file, data memory, then PC. It streams each word out over a valid/ready interface. It is the in-silicon reader of processor state, used for post-run checking on FPGA, where a simulator-only backdoor dump is unavailable.

---
 rtl/mem_state_dump.sv | 184 ++++++++++++++++++
 tb/tb_mem_state_dump.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_state_dump.sv
// -----------------------------------------------------------------------------
// mem_state_dump
//
// In-silicon reader of RISC-V architectural state. On a start request it asks
// the core to freeze, then walks the register file, the data memory and
// finally the PC through read-only ports, and streams every word out over a
// valid/ready interface tagged with its source and index. Used for post-run
// state checking on FPGA, where no simulator backdoor exists.
//
// Ports:
//   clk        in   rising-edge clock
//   rst        in   synchronous reset, active low (0 = reset)
//   start      in   dump request, only looked at while idle
//   halt_req   out  freeze request to the core (HALT through OUT)
//   halt_ack   in   core reports it is frozen (only looked at in HALT)
//   rf_raddr   out  register file read address (0 unless reading RF)
//   rf_rdata   in   register file read data, one cycle after rf_raddr
//   dm_raddr   out  data memory word address (0 unless reading DM)
//   dm_rdata   in   data memory read data, one cycle after dm_raddr
//   pc_in      in   current PC value
//   out_valid  out  stream word valid
//   out_ready  in   stream consumer ready
//   out_data   out  dumped word
//   out_src    out  word source: 0 = RF, 1 = DM, 2 = PC
//   out_idx    out  word index within its source (0 for the PC)
//   busy       out  high whenever the engine is not idle
//   done       out  single-cycle pulse when the dump has completed
// -----------------------------------------------------------------------------
module mem_state_dump #(
    parameter int XLEN      = 32,
    parameter int RF_WORDS  = 32,
    parameter int DM_WORDS  = 1024,
    parameter int DM_ADDR_W = 10
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    output logic                 halt_req,
    input  logic                 halt_ack,
    output logic [4:0]           rf_raddr,
    input  logic [XLEN-1:0]      rf_rdata,
    output logic [DM_ADDR_W-1:0] dm_raddr,
    input  logic [XLEN-1:0]      dm_rdata,
    input  logic [XLEN-1:0]      pc_in,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [XLEN-1:0]      out_data,
    output logic [1:0]           out_src,
    output logic [DM_ADDR_W-1:0] out_idx,
    output logic                 busy,
    output logic                 done
);

    // The index must cover both the 5-bit RF range and the DM address range.
    localparam int IDX_W = (DM_ADDR_W > 5) ? DM_ADDR_W : 5;

    localparam logic [IDX_W-1:0] RF_LAST = IDX_W'(RF_WORDS - 1);
    localparam logic [IDX_W-1:0] DM_LAST = IDX_W'(DM_WORDS - 1);
    localparam logic [IDX_W-1:0] IDX_ONE = IDX_W'(1);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_HALT = 3'd1;
    localparam logic [2:0] S_RD   = 3'd2;
    localparam logic [2:0] S_CAP  = 3'd3;
    localparam logic [2:0] S_OUT  = 3'd4;
    localparam logic [2:0] S_FIN  = 3'd5;

    localparam logic [1:0] SRC_RF = 2'd0;
    localparam logic [1:0] SRC_DM = 2'd1;
    localparam logic [1:0] SRC_PC = 2'd2;

    logic [2:0]      state;
    logic [IDX_W-1:0] idx;
    logic [1:0]      src;
    // Set after the first HALT cycle. halt_ack is only trusted once halt_req
    // has been visible to the core for a full cycle, so an ack level left
    // high from an earlier freeze is not mistaken for a fresh one.
    logic            halt_seen;

    logic            last_word;
    logic [XLEN-1:0] cap_word;

    // Read addresses come straight from the walk registers; the unused port
    // is parked at 0 so the other memory sees no address activity.
    assign rf_raddr = (src == SRC_RF) ? idx[4:0] : 5'd0;
    assign dm_raddr = (src == SRC_DM) ? idx[DM_ADDR_W-1:0] : '0;

    assign halt_req  = (state == S_HALT) || (state == S_RD) ||
                       (state == S_CAP)  || (state == S_OUT);
    assign busy      = (state != S_IDLE);
    assign out_valid = (state == S_OUT);
    assign done      = (state == S_FIN);

    always_comb begin
        last_word = 1'b0;
        cap_word  = '0;
        case (src)
            SRC_RF: begin
                last_word = (idx == RF_LAST);
                cap_word  = rf_rdata;
            end
            SRC_DM: begin
                last_word = (idx == DM_LAST);
                cap_word  = dm_rdata;
            end
            SRC_PC: begin
                last_word = 1'b1;
                cap_word  = pc_in;
            end
            default: begin
                last_word = 1'b1;
                cap_word  = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= S_IDLE;
            idx       <= '0;
            src       <= SRC_RF;
            halt_seen <= 1'b0;
            out_data  <= '0;
            out_src   <= SRC_RF;
            out_idx   <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    halt_seen <= 1'b0;
                    if (start) begin
                        state <= S_HALT;
                        idx   <= '0;
                        src   <= SRC_RF;
                    end
                end

                S_HALT: begin
                    halt_seen <= 1'b1;
                    if (halt_seen && halt_ack) begin
                        state <= S_RD;
                    end
                end

                // Address is already on the read port; memories answer next cycle.
                S_RD: begin
                    state <= S_CAP;
                end

                S_CAP: begin
                    out_data <= cap_word;
                    out_src  <= src;
                    out_idx  <= idx[DM_ADDR_W-1:0];
                    state    <= S_OUT;
                end

                // Output registers only change in CAP, so they hold through stalls.
                S_OUT: begin
                    if (out_ready) begin
                        if (src == SRC_PC) begin
                            state <= S_FIN;
                        end else begin
                            state <= S_RD;
                            if (last_word) begin
                                src <= (src == SRC_RF) ? SRC_DM : SRC_PC;
                                idx <= '0;
                            end else begin
                                idx <= idx + IDX_ONE;
                            end
                        end
                    end
                end

                S_FIN: begin
                    state <= S_IDLE;
                end

                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_state_dump.sv
`timescale 1ns/1ps
module tb_mem_state_dump;

    localparam int XLEN      = 32;
    localparam int RF_WORDS  = 32;
    localparam int DM_WORDS  = 4;
    localparam int DM_ADDR_W = 10;
    localparam int NWORDS    = RF_WORDS + DM_WORDS + 1;

    logic                 clk = 1'b0;
    logic                 rst = 1'b0;
    logic                 start = 1'b0;
    logic                 halt_req;
    logic                 halt_ack = 1'b0;
    logic [4:0]           rf_raddr;
    logic [XLEN-1:0]      rf_rdata = '0;
    logic [DM_ADDR_W-1:0] dm_raddr;
    logic [XLEN-1:0]      dm_rdata = '0;
    logic [XLEN-1:0]      pc_in = 32'h0000_0040;
    logic                 out_valid;
    logic                 out_ready = 1'b0;
    logic [XLEN-1:0]      out_data;
    logic [1:0]           out_src;
    logic [DM_ADDR_W-1:0] out_idx;
    logic                 busy;
    logic                 done;

    mem_state_dump #(
        .XLEN(XLEN), .RF_WORDS(RF_WORDS), .DM_WORDS(DM_WORDS), .DM_ADDR_W(DM_ADDR_W)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .halt_req(halt_req), .halt_ack(halt_ack),
        .rf_raddr(rf_raddr), .rf_rdata(rf_rdata), .dm_raddr(dm_raddr), .dm_rdata(dm_rdata),
        .pc_in(pc_in), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_src(out_src), .out_idx(out_idx), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Synchronous-read memory models: data one cycle after the address.
    logic [XLEN-1:0] rf_mem [0:31];
    logic [XLEN-1:0] dm_mem [0:1023];
    always @(posedge clk) begin
        rf_rdata <= rf_mem[rf_raddr];
        dm_rdata <= dm_mem[dm_raddr];
    end

    int total = 0;
    int bad   = 0;

    // Captured stream of the most recent dump.
    logic [XLEN-1:0]      cap_data [0:63];
    logic [1:0]           cap_src  [0:63];
    logic [DM_ADDR_W-1:0] cap_idx  [0:63];
    int                   cap_edge [0:63];
    int cap_n, done_cnt, done_cyc, stall_err, first_valid_cyc;

    function automatic void exp_word(input int n, output logic [XLEN-1:0] d,
                                     output logic [1:0] s, output logic [DM_ADDR_W-1:0] i);
        if (n < RF_WORDS) begin
            d = rf_mem[n]; s = 2'd0; i = DM_ADDR_W'(n);
        end else if (n < RF_WORDS + DM_WORDS) begin
            d = dm_mem[n - RF_WORDS]; s = 2'd1; i = DM_ADDR_W'(n - RF_WORDS);
        end else begin
            d = pc_in; s = 2'd2; i = '0;
        end
    endfunction

    // Drives out_ready and records every handshake until done or budget expiry.
    // Optionally re-pulses start after word repulse_at and on the FIN cycle.
    task automatic capture(input int max_cyc, input bit rnd_ready, input int repulse_at);
        bit stalled;
        logic [XLEN-1:0] hd;
        logic [1:0] hs;
        logic [DM_ADDR_W-1:0] hi;
        for (int i = 0; i < 64; i++) begin
            cap_data[i] = 'x; cap_src[i] = 'x; cap_idx[i] = 'x; cap_edge[i] = -1;
        end
        cap_n = 0; done_cnt = 0; done_cyc = -1; stall_err = 0; first_valid_cyc = -1;
        stalled = 1'b0; hd = '0; hs = '0; hi = '0;
        for (int c = 0; c < max_cyc; c++) begin
            @(negedge clk);
            start = 1'b0;
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
                if (repulse_at >= 0) start = 1'b1;
                break;
            end
            out_ready = rnd_ready ? 1'($urandom % 2) : 1'b1;
            if (stalled && (!out_valid || out_data !== hd || out_src !== hs || out_idx !== hi))
                stall_err++;
            if (out_valid) begin
                if (first_valid_cyc < 0) first_valid_cyc = cyc;
                if (out_ready) begin
                    if (cap_n < 64) begin
                        cap_data[cap_n] = out_data; cap_src[cap_n] = out_src;
                        cap_idx[cap_n] = out_idx; cap_edge[cap_n] = cyc + 1;
                    end
                    cap_n++;
                    stalled = 1'b0;
                    if (repulse_at >= 0 && cap_n == repulse_at) start = 1'b1;
                end else begin
                    stalled = 1'b1;
                    hd = out_data; hs = out_src; hi = out_idx;
                end
            end
        end
        out_ready = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b0; start = 1'b0; halt_ack = 1'b1; out_ready = 1'b1;
        repeat (3) @(negedge clk);
        total++; if (halt_req !== 1'b0) begin bad++; $display("FAIL reset_halt_req got=%0b want=0", halt_req); end
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%0b want=0", out_valid); end
        total++; if (out_data !== 32'h0) begin bad++; $display("FAIL reset_out_data got=%h want=0", out_data); end
        total++; if (out_src !== 2'd0) begin bad++; $display("FAIL reset_out_src got=%0d want=0", out_src); end
        total++; if (out_idx !== 10'd0) begin bad++; $display("FAIL reset_out_idx got=%0d want=0", out_idx); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%0b want=0", busy); end
        total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done got=%0b want=0", done); end
        rst = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_full_dump();
        int k, err, eerr;
        logic [XLEN-1:0] ed; logic [1:0] es; logic [DM_ADDR_W-1:0] ei;
        halt_ack = 1'b1;
        @(negedge clk);
        start = 1'b1;
        k = cyc + 1;
        capture(400, 1'b0, -1);
        err = 0; eerr = 0;
        for (int n = 0; n < NWORDS; n++) begin
            exp_word(n, ed, es, ei);
            if (cap_data[n] !== ed || cap_src[n] !== es || cap_idx[n] !== ei) err++;
            if (cap_edge[n] != k + 5 + 3 * n) eerr++;
        end
        total++; if (cap_n !== NWORDS) begin bad++; $display("FAIL full_count got=%0d want=%0d", cap_n, NWORDS); end
        total++; if (err !== 0) begin bad++; $display("FAIL full_sequence wrong_words=%0d want=0", err); end
        total++; if (eerr !== 0) begin bad++; $display("FAIL full_hs_timing wrong_edges=%0d want=0 (first edge %0d want %0d)", eerr, cap_edge[0] - k, 5); end
        total++; if (first_valid_cyc !== k + 4) begin bad++; $display("FAIL full_first_valid got=k+%0d want=k+4", first_valid_cyc - k); end
        total++; if (done_cyc !== k + 113) begin bad++; $display("FAIL full_done_edge got=k+%0d want=k+113", done_cyc - k); end
        total++; if (done_cnt !== 1) begin bad++; $display("FAIL full_done_count got=%0d want=1", done_cnt); end
        total++; if ({cap_src[5], cap_idx[5], cap_data[5]} !== {2'd0, 10'd5, 32'hDEADBEEF})
            begin bad++; $display("FAIL preload_rf5 got=%0d/%0d/%h want=0/5/deadbeef", cap_src[5], cap_idx[5], cap_data[5]); end
        total++; if ({cap_src[34], cap_idx[34], cap_data[34]} !== {2'd1, 10'd2, 32'h12345678})
            begin bad++; $display("FAIL preload_dm2 got=%0d/%0d/%h want=1/2/12345678", cap_src[34], cap_idx[34], cap_data[34]); end
        total++; if ({cap_src[36], cap_idx[36], cap_data[36]} !== {2'd2, 10'd0, 32'h00000040})
            begin bad++; $display("FAIL preload_pc got=%0d/%0d/%h want=2/0/00000040", cap_src[36], cap_idx[36], cap_data[36]); end
        @(negedge clk);
        total++; if (busy !== 1'b0 || cyc != k + 114) begin bad++; $display("FAIL full_busy_end got=%0b at k+%0d want=0 at k+114", busy, cyc - k); end
    endtask

    task automatic test_delayed_ack();
        int err, viol;
        bit seen;
        logic [XLEN-1:0] ed; logic [1:0] es; logic [DM_ADDR_W-1:0] ei;
        halt_ack = 1'b0;
        @(negedge clk);
        start = 1'b1;
        seen = 1'b0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            start = 1'b0;
            if (halt_req) begin seen = 1'b1; break; end
        end
        total++; if (seen !== 1'b1) begin bad++; $display("FAIL ack_halt_req_rise got=%0b want=1", halt_req); end
        viol = 0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (out_valid !== 1'b0 || rf_raddr !== 5'd0 || dm_raddr !== 10'd0 || halt_req !== 1'b1) viol++;
        end
        total++; if (viol !== 0) begin bad++; $display("FAIL ack_wait_quiet violations=%0d want=0", viol); end
        halt_ack = 1'b1;
        capture(400, 1'b0, -1);
        err = 0;
        for (int n = 0; n < NWORDS; n++) begin
            exp_word(n, ed, es, ei);
            if (cap_data[n] !== ed || cap_src[n] !== es || cap_idx[n] !== ei) err++;
        end
        total++; if (cap_n !== NWORDS) begin bad++; $display("FAIL ack_count got=%0d want=%0d", cap_n, NWORDS); end
        total++; if (err !== 0) begin bad++; $display("FAIL ack_sequence wrong_words=%0d want=0", err); end
    endtask

    task automatic test_random_ready();
        int err;
        logic [XLEN-1:0] ed; logic [1:0] es; logic [DM_ADDR_W-1:0] ei;
        @(negedge clk);
        start = 1'b1;
        capture(2000, 1'b1, -1);
        err = 0;
        for (int n = 0; n < NWORDS; n++) begin
            exp_word(n, ed, es, ei);
            if (cap_data[n] !== ed || cap_src[n] !== es || cap_idx[n] !== ei) err++;
        end
        total++; if (cap_n !== NWORDS) begin bad++; $display("FAIL rnd_count got=%0d want=%0d", cap_n, NWORDS); end
        total++; if (err !== 0) begin bad++; $display("FAIL rnd_sequence wrong_words=%0d want=0", err); end
        total++; if (stall_err !== 0) begin bad++; $display("FAIL rnd_stall_stable unstable_cycles=%0d want=0", stall_err); end
        total++; if (done_cnt !== 1) begin bad++; $display("FAIL rnd_done_count got=%0d want=1", done_cnt); end
    endtask

    task automatic test_reset_mid();
        int err;
        bit found;
        logic [XLEN-1:0] ed; logic [1:0] es; logic [DM_ADDR_W-1:0] ei;
        @(negedge clk);
        start = 1'b1;
        found = 1'b0;
        for (int c = 0; c < 200; c++) begin
            @(negedge clk);
            start = 1'b0;
            out_ready = 1'b1;
            if (out_valid && out_src == 2'd1 && out_idx == 10'd1) begin found = 1'b1; break; end
        end
        total++; if (found !== 1'b1) begin bad++; $display("FAIL rstmid_reach_dm1 got=%0b want=1", found); end
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rstmid_out_valid got=%0b want=0", out_valid); end
        total++; if (halt_req !== 1'b0) begin bad++; $display("FAIL rstmid_halt_req got=%0b want=0", halt_req); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL rstmid_busy got=%0b want=0", busy); end
        @(negedge clk);
        start = 1'b1;
        capture(400, 1'b0, -1);
        err = 0;
        for (int n = 0; n < NWORDS; n++) begin
            exp_word(n, ed, es, ei);
            if (cap_data[n] !== ed || cap_src[n] !== es || cap_idx[n] !== ei) err++;
        end
        total++; if ({cap_src[0], cap_idx[0], cap_data[0]} !== {2'd0, 10'd0, rf_mem[0]})
            begin bad++; $display("FAIL rstmid_restart_first got=%0d/%0d/%h want=0/0/%h", cap_src[0], cap_idx[0], cap_data[0], rf_mem[0]); end
        total++; if (cap_n !== NWORDS || err !== 0) begin bad++; $display("FAIL rstmid_restart_seq count=%0d wrong_words=%0d want=%0d/0", cap_n, err, NWORDS); end
    endtask

    task automatic test_repulse();
        int err, viol;
        logic [XLEN-1:0] ed; logic [1:0] es; logic [DM_ADDR_W-1:0] ei;
        @(negedge clk);
        start = 1'b1;
        capture(400, 1'b0, 10);
        err = 0;
        for (int n = 0; n < NWORDS; n++) begin
            exp_word(n, ed, es, ei);
            if (cap_data[n] !== ed || cap_src[n] !== es || cap_idx[n] !== ei) err++;
        end
        viol = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            start = 1'b0;
            if (busy !== 1'b0 || done !== 1'b0 || out_valid !== 1'b0) viol++;
        end
        total++; if (cap_n !== NWORDS) begin bad++; $display("FAIL repulse_count got=%0d want=%0d", cap_n, NWORDS); end
        total++; if (err !== 0) begin bad++; $display("FAIL repulse_sequence wrong_words=%0d want=0", err); end
        total++; if (done_cnt !== 1) begin bad++; $display("FAIL repulse_done_count got=%0d want=1", done_cnt); end
        total++; if (viol !== 0) begin bad++; $display("FAIL repulse_no_restart active_cycles=%0d want=0", viol); end
    endtask

    initial begin
        for (int i = 0; i < 32; i++) rf_mem[i] = 32'h1100_0000 + 32'(i * 3);
        for (int i = 0; i < 1024; i++) dm_mem[i] = 32'hA500_0000 + 32'(i);
        rf_mem[5] = 32'hDEADBEEF;
        dm_mem[2] = 32'h12345678;
        pc_in     = 32'h0000_0040;

        test_reset();
        test_full_dump();
        test_delayed_ack();
        test_random_ready();
        test_reset_mid();
        test_repulse();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog simulation time limit reached total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

endmodule
